// File: rtl/gpio_cond_if.sv
// gpio_cond_if: gpio input bus, debounced value and change-event FIFO port; irq signals exist only with GPIO_COND_IRQ_EN.
interface gpio_cond_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] stable_out;
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_data;
  logic [WIDTH-1:0] evt_mask;
  logic             evt_overflow;
  logic             ovf_clr;
`ifdef GPIO_COND_IRQ_EN
  logic [WIDTH-1:0] irq_rise_en;
  logic [WIDTH-1:0] irq_fall_en;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] irq_status;
  logic             irq;
  modport master (output gpio_in, evt_ready, ovf_clr, irq_rise_en, irq_fall_en, irq_clr,
                  input stable_out, evt_valid, evt_data, evt_mask, evt_overflow, irq_status, irq);
  modport slave  (input gpio_in, evt_ready, ovf_clr, irq_rise_en, irq_fall_en, irq_clr,
                  output stable_out, evt_valid, evt_data, evt_mask, evt_overflow, irq_status, irq);
`else
  modport master (output gpio_in, evt_ready, ovf_clr,
                  input stable_out, evt_valid, evt_data, evt_mask, evt_overflow);
  modport slave  (input gpio_in, evt_ready, ovf_clr,
                  output stable_out, evt_valid, evt_data, evt_mask, evt_overflow);
`endif
endinterface

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: synchronise and debounce a gpio bus, queue committed changes in a FIFO.
// Optional GPIO_COND_IRQ_EN adds per-bit rise/fall interrupt status.
module gpio_input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input logic        clk,
  input logic        rst,
  gpio_cond_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync, stable, commit_mask, stable_next;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_mask [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] last_data, last_mask;
  logic             ovf, empty, full, push, pop, wr_en;
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  always_comb begin
    commit_mask = '0;
    for (int b = 0; b < WIDTH; b++)
      commit_mask[b] = (sync[b] != stable[b]) && (cnt[b] == CW'(DEBOUNCE_CYCLES - 1));
    stable_next = stable ^ commit_mask;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= '0;
      for (int b = 0; b < WIDTH; b++) cnt[b] <= '0;
    end else begin
      stable <= stable_next;
      for (int b = 0; b < WIDTH; b++)
        cnt[b] <= (sync[b] == stable[b] || commit_mask[b]) ? '0 : cnt[b] + 1'b1;
    end
  end
  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = |commit_mask;
  assign pop   = !empty && bus.evt_ready;
  assign wr_en = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr[AW-1:0]] <= stable_next;
      mem_mask[wr_ptr[AW-1:0]] <= commit_mask;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_data <= '0;
      last_mask <= '0;
      ovf       <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(wr_en);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      if (pop) begin
        last_data <= mem_data[rd_ptr[AW-1:0]];
        last_mask <= mem_mask[rd_ptr[AW-1:0]];
      end
      ovf <= (push && full && !pop) ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf;
    end
  end
  // When empty the outputs hold the last popped entry rather than stale memory.
  assign bus.stable_out   = stable;
  assign bus.evt_valid    = !empty;
  assign bus.evt_data     = empty ? last_data : mem_data[rd_ptr[AW-1:0]];
  assign bus.evt_mask     = empty ? last_mask : mem_mask[rd_ptr[AW-1:0]];
  assign bus.evt_overflow = ovf;
`ifdef GPIO_COND_IRQ_EN
  logic [WIDTH-1:0] irq_status, irq_set, irq_next;
  logic             irq_q;
  always_comb begin
    irq_set  = commit_mask & ((stable_next & bus.irq_rise_en) | (~stable_next & bus.irq_fall_en));
    irq_next = (irq_status & ~bus.irq_clr) | irq_set;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_status <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_status <= irq_next;
      irq_q      <= |irq_next;
    end
  end
  assign bus.irq_status = irq_status;
  assign bus.irq        = irq_q;
`endif
endmodule
